// File: rtl/mem_bus_master_if.sv
// CPU request/response and Avalon-style data bus bundle for mem_bus_master.
interface mem_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
               readdata, waitrequest,
        output req_ready, resp_valid, resp_err, resp_rdata,
               address, read, write, writedata, byteenable
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
               readdata, waitrequest,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               address, read, write, writedata, byteenable
    );
endinterface

// File: rtl/mem_bus_master.sv
// Load/store bus initiator: one CPU access at a time onto a word-addressed bus,
// big-endian byte lanes, waitrequest timeout and sign/zero-extended loads.
module mem_bus_master #(
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              reset,
    mem_bus_master_if.master bus
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, RDATA, ERR} state_t;
    state_t state, state_n;

    logic [CW-1:0] wait_cnt;
    logic [31:0]   addr_q, wdata_q, wdata_n, rdata_q, load_data;
    logic [3:0]    be_q, be_n;
    logic [1:0]    size_q;
    logic          write_q, signed_q, bad_n;
    logic          ready, rd, wr, resp_valid_q, resp_err_q;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    // Lane mapping is big-endian: byte offset o lands on lane 3-o.
    always_comb begin
        be_n    = 4'b0000;
        wdata_n = '0;
        bad_n   = 1'b0;
        case (bus.req_size)
            2'b00: begin
                be_n    = 4'b1000 >> bus.req_addr[1:0];
                wdata_n = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_n    = bus.req_addr[1] ? 4'b0011 : 4'b1100;
                wdata_n = {2{bus.req_wdata[15:0]}};
                bad_n   = bus.req_addr[0];
            end
            2'b10: begin
                be_n    = 4'b1111;
                wdata_n = bus.req_wdata;
                bad_n   = (bus.req_addr[1:0] != 2'b00);
            end
            default: bad_n = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte   = 8'h00;
        ld_half   = addr_q[1] ? bus.readdata[15:0] : bus.readdata[31:16];
        load_data = bus.readdata;
        case (addr_q[1:0])
            2'd0: ld_byte = bus.readdata[31:24];
            2'd1: ld_byte = bus.readdata[23:16];
            2'd2: ld_byte = bus.readdata[15:8];
            default: ld_byte = bus.readdata[7:0];
        endcase
        case (size_q)
            2'b00: load_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01: load_data = {{16{signed_q & ld_half[15]}}, ld_half};
            default: load_data = bus.readdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        ready   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) state_n = bad_n ? ERR : BUS;
            end
            BUS: begin
                rd = ~write_q;
                wr = write_q;
                if (!bus.waitrequest)                     state_n = write_q ? IDLE : RDATA;
                else if (wait_cnt == CW'(TIMEOUT - 1))    state_n = ERR;
            end
            RDATA:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            size_q       <= '0;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            if (state == IDLE && bus.req_valid) begin
                addr_q   <= bus.req_addr;
                wdata_q  <= wdata_n;
                be_q     <= be_n;
                size_q   <= bus.req_size;
                write_q  <= bus.req_write;
                signed_q <= bus.req_signed;
                wait_cnt <= '0;
            end
            case (state)
                BUS: begin
                    if (bus.waitrequest) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end else if (write_q) begin
                        resp_valid_q <= 1'b1;
                        rdata_q      <= '0;
                    end
                end
                RDATA: begin
                    resp_valid_q <= 1'b1;
                    rdata_q      <= load_data;
                end
                ERR: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    rdata_q      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = ready;
    assign bus.read       = rd;
    assign bus.write      = wr;
    assign bus.address    = {addr_q[31:2], 2'b00};
    assign bus.writedata  = wdata_q;
    assign bus.byteenable = be_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// Randomised bench for mem_bus_master: byte-level memory model, slave with
// programmable wait states, latency/lane/extension/timeout/reset checks.
module tb_mem_bus_master;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];

    mem_bus_master_if b ();

    mem_bus_master #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access; starts and ends just after a falling edge so calls chain back-to-back.
    task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          input string tag);
        int o, nbytes, idx, exp_lat, exp_strobes, strobes, lat, rdy_busy, stab_bad, dir_bad, k;
        logic bad, tmo, done, ack, got_err, got_rdy;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd, v, mask, got_rd;
        o      = int'(a[1:0]);
        idx    = int'(a[5:2]);
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bad    = (sz == 2'd3) || (o % nbytes != 0);
        tmo    = !bad && waits >= TO;
        exp_be = 4'b0000;
        if (!bad) for (int i = 0; i < nbytes; i++) exp_be[3 - o - i] = 1'b1;
        exp_wd = (nbytes == 1) ? {4{wd[7:0]}} : (nbytes == 2) ? {2{wd[15:0]}} : wd;
        exp_rd = 32'h0;
        if (!bad && !tmo && !w) begin
            v = ref_mem[idx] >> (8 * (4 - o - nbytes));
            if (nbytes < 4) begin
                mask = (32'h1 << (8 * nbytes)) - 32'h1;
                v = v & mask;
                if (sg && v[8 * nbytes - 1]) v = v | ~mask;
            end
            exp_rd = v;
        end
        exp_lat     = bad ? 2 : tmo ? TO + 2 : w ? 2 + waits : 3 + waits;
        exp_strobes = bad ? 0 : tmo ? TO : waits + 1;

        chk({tag, " ready"}, {31'b0, b.req_ready}, 32'h1);
        b.req_valid = 1'b1; b.req_write = w; b.req_size = sz; b.req_signed = sg;
        b.req_addr = a; b.req_wdata = wd;
        @(posedge clk);
        #1;
        b.req_valid = 1'b0;
        b.req_write = 1'($urandom); b.req_size = 2'($urandom); b.req_signed = 1'($urandom);
        b.req_addr = $urandom; b.req_wdata = $urandom;

        strobes = 0; lat = 0; rdy_busy = 0; stab_bad = 0; dir_bad = 0; k = 0;
        done = 1'b0; ack = 1'b0; got_err = 1'b0; got_rd = 32'h0; got_rdy = 1'b0;
        while (!done && k < TO + 20) begin
            @(negedge clk);
            k++;
            if (b.resp_valid) begin
                done = 1'b1; lat = k; got_err = b.resp_err; got_rd = b.resp_rdata; got_rdy = b.req_ready;
            end else begin
                if (b.req_ready) rdy_busy++;
                if (b.read || b.write) begin
                    strobes++;
                    if (b.address != {a[31:2], 2'b00} || b.byteenable != exp_be ||
                        (b.write && b.writedata != exp_wd)) stab_bad++;
                    if (b.write != w || b.read == w) dir_bad++;
                    b.waitrequest = (strobes <= waits);
                    if (!b.waitrequest) begin
                        ack = !b.write;
                        if (b.write)
                            for (int l = 0; l < 4; l++)
                                if (b.byteenable[l]) mem[idx][8*l +: 8] = b.writedata[8*l +: 8];
                    end
                end else begin
                    b.waitrequest = 1'($urandom);
                end
                @(posedge clk);
                #1;
                b.readdata = ack ? mem[idx] : $urandom;
                ack = 1'b0;
            end
        end
        b.waitrequest = 1'b0;

        chk({tag, " resp_seen"}, {31'b0, done}, 32'h1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " err"}, {31'b0, got_err}, {31'b0, bad | tmo});
        chk({tag, " rdata"}, got_rd, exp_rd);
        chk({tag, " strobes"}, strobes, exp_strobes);
        chk({tag, " bus_fields"}, stab_bad, 0);
        chk({tag, " direction"}, dir_bad, 0);
        chk({tag, " busy_not_ready"}, rdy_busy, 0);
        chk({tag, " ready_at_resp"}, {31'b0, got_rdy}, 32'h1);

        if (!bad && !tmo && w)
            for (int i = 0; i < nbytes; i++)
                ref_mem[idx][8*(3 - o - i) +: 8] = wd[8*(nbytes - 1 - i) +: 8];
    endtask

    initial begin
        int rv_cnt, diff;
        b.req_valid = 1'b0; b.req_write = 1'b0; b.req_size = 2'd0; b.req_signed = 1'b0;
        b.req_addr = 32'h0; b.req_wdata = 32'h0; b.readdata = 32'h0; b.waitrequest = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h12345678; ref_mem[4] = 32'h12345678;
        mem[8] = 32'h00FF0000; ref_mem[8] = 32'h00FF0000;

        repeat (2) @(negedge clk);
        chk("rst read", {31'b0, b.read}, 32'h0);
        chk("rst write", {31'b0, b.write}, 32'h0);
        chk("rst resp_valid", {31'b0, b.resp_valid}, 32'h0);
        chk("rst resp_err", {31'b0, b.resp_err}, 32'h0);
        chk("rst resp_rdata", b.resp_rdata, 32'h0);
        chk("rst address", b.address, 32'h0);
        chk("rst writedata", b.writedata, 32'h0);
        chk("rst byteenable", {28'b0, b.byteenable}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "lw");
        access(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 0, "lb");
        access(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 0, "lbu");
        access(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF, 0, "sh");
        access(1'b1, 2'd0, 1'b0, 32'h33, 32'h000000AA, 0, "sb");
        access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0, "lw_after_st");
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, "lw_stall");
        access(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 256, "lw_timeout");
        access(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0, "lw_mis");
        access(1'b0, 2'd1, 1'b1, 32'h01, 32'h0, 0, "lh_mis");
        access(1'b0, 2'd3, 1'b0, 32'h04, 32'h0, 0, "size11");
        access(1'b1, 2'd2, 1'b0, 32'h38, 32'hCAFEF00D, 0, "sw_b2b_a");
        access(1'b1, 2'd2, 1'b0, 32'h3C, 32'h0BADBEEF, 0, "sw_b2b_b");

        for (int n = 0; n < 60; n++)
            access(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 63)),
                   $urandom, $urandom_range(0, 3), $sformatf("rnd%0d", n));

        diff = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) diff++;
        chk("mem_image", diff, 0);

        // reset while the bus is stalled
        b.req_valid = 1'b1; b.req_write = 1'b0; b.req_size = 2'd2; b.req_addr = 32'h24;
        b.waitrequest = 1'b1;
        @(posedge clk);
        #1 b.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall read", {31'b0, b.read}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async rst read", {31'b0, b.read}, 32'h0);
        chk("async rst resp_valid", {31'b0, b.resp_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        b.waitrequest = 1'b0;
        rv_cnt = 0;
        chk("post rst ready", {31'b0, b.req_ready}, 32'h1);
        repeat (5) begin
            @(negedge clk);
            if (b.resp_valid || b.read || b.write) rv_cnt++;
        end
        chk("post rst quiet", rv_cnt, 0);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1, "lw_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Load/store bus initiator for the MIPS core. It takes one load or store at a time from the execute/memory stage and drives the word-addressed Avalon-style data bus (address, read, write, writedata, byteenable, readdata, waitrequest) that the system RAM model responds to. It generates byte lanes for byte, halfword and word accesses, honours waitrequest with a timeout, and returns sign- or zero-extended load data.

## Interface
- `TIMEOUT`, default 255: maximum number of consecutive cycles with waitrequest high before the access aborts. Must be ≥1. The counter is 8 bits for the default value.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 1: CPU request present.
- `req_ready` output 1: block is in IDLE and can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 = byte, 01 = half, 10 = word; 11 is illegal.
- `req_signed` input 1: sign-extend load data (byte/half only).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_err` output 1: qualifies resp_valid; set for misaligned, illegal size, or timeout.
- `resp_rdata` output 32: load result; 0 for stores and errors.
- `address` output 32: {req_addr[31:2], 2'b00}.
- `read`, `write` output 1: bus strobes, mutually exclusive.
- `writedata` output 32: lane-replicated store data.
- `byteenable` output 4: active lanes.
- `readdata` input 32: slave data, registered by the slave and valid in the cycle after acceptance.
- `waitrequest` input 1: slave stall.

## Operation
- Lane mapping is big-endian. Lane k is bits [8k+7:8k]. Byte offset o = req_addr[1:0] maps to lane 3−o.
- Byte access: byteenable = 4'b1000 >> o. writedata = {4{wdata[7:0]}}.
- Half access: o=0 gives 4'b1100 and o=2 gives 4'b0011. writedata = {2{wdata[15:0]}}. o odd is misaligned.
- Word access: byteenable = 4'b1111 and writedata = wdata. o≠0 is misaligned.
- The request is latched when req_valid && req_ready.
- States and transitions:
  - IDLE: req_ready=1. On accept, go to ERR if misaligned or size=11, else go to BUS.
  - BUS: read or write high, with address, byteenable and writedata stable.
    - A rising edge with waitrequest=0 is acceptance. A store goes to IDLE with resp_valid pulsed. A load goes to RDATA.
    - With waitrequest=1 the wait counter increments. When the counter reaches TIMEOUT, the strobes drop and the state goes to ERR.
  - RDATA: strobes low. Select readdata by the latched lane, extend it, and register it into resp_rdata. Go to IDLE with resp_valid pulsed.
  - ERR: go to IDLE with resp_valid=1 and resp_err=1. No bus strobe is ever asserted for a misaligned or illegal access.
- Extension: byte and half loads are sign-extended when req_signed=1, else zero-extended. req_signed is ignored for words.
- The wait counter clears on entry to BUS.
- req_ready is 1 during the resp_valid cycle, so back-to-back requests are allowed.
- Requests are not accepted outside IDLE. req_* changes while the block is busy are ignored.

## Timing
- Reset (asynchronous, any state): state=IDLE, and read, write, resp_valid, resp_err all =0. resp_rdata, address, writedata and byteenable =0. req_ready=1 once reset deasserts. An in-flight access is dropped with no response.
- Let A be the accept edge:
  - BUS is cycle A+1.
  - With zero wait states, store resp_valid is in cycle A+2. Load data is sampled in cycle A+2 (RDATA) and load resp_valid is in cycle A+3.
  - Each wait cycle adds 1 to these.
- Error response: resp_valid in cycle A+2 with no bus activity.
- Timeout: strobes are high for exactly TIMEOUT cycles, then resp_err arrives the next cycle.
- resp_valid and resp_err are high for exactly one cycle. resp_rdata holds its value until the next response.

## Test plan
- **lw, no waits:** addr 0x00000010, RAM word 0x12345678 → read=1 for 1 cycle, byteenable=1111, address 0x10, resp_rdata=0x12345678 at A+3, resp_err=0.
- **lb/lbu, sign handling:** lb at offset 1 of word 0x00FF0000 → byteenable=0100, resp_rdata=0xFFFFFFFF. lbu at the same address → 0x000000FF.
- **sh and sb lanes:** sh 0xBEEF at offset 2 → write=1, byteenable=0011, writedata=0xBEEFBEEF, resp at A+2. sb 0xAA at offset 3 → byteenable=0001, writedata=0xAAAAAAAA.
- **Waitrequest stall:**
  - Hold waitrequest=1 for 3 cycles on an lw → read stays high for 4 cycles with address stable, and resp_valid arrives at A+6.
  - Hold waitrequest=1 for 256 cycles (TIMEOUT=255) → read is high for 255 cycles, then drops. resp_err=1 and resp_rdata=0.
- **Misaligned/illegal:** lw at 0x2, lh at 0x1, and size=11 → no read/write ever asserted, resp_valid=resp_err=1 at A+2.
- **Reset mid-access and back-to-back:**
  - Assert reset during BUS with waitrequest=1 → read=0 immediately (asynchronously), no resp_valid, req_ready=1 after release.
  - Two stores issued back-to-back with waits=0 → second accepted in the first's resp_valid cycle.
